bcd_timekeeper: RTL and testbench

BCD_TIMEKEEPER -- requirements
Module: bcd_timekeeper

---
 rtl/bcd_timekeeper.sv | 157 +++++++++++++++
 tb/tb_bcd_timekeeper.sv | 453 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_timekeeper.sv
`default_nettype none
// ============================================================================
// Module   : bcd_timekeeper
// Summary  : 24-hour BCD time-of-day counter with button-driven set modes and
//            an optional alarm, built when TIMEKEEPER_ALARM_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_timekeeper #(
    parameter int TICKS_PER_SEC = 100000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_mode,
    input  logic        btn_inc,
    output logic [31:0] to_display,
    output logic [2:0]  mode,
    output logic        alarm
);

    localparam int                   c_PRESC_W    = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [c_PRESC_W-1:0] c_PRESC_LAST = c_PRESC_W'(TICKS_PER_SEC - 1);

    localparam logic [2:0] c_RUN     = 3'd0;
    localparam logic [2:0] c_SET_HR  = 3'd1;
    localparam logic [2:0] c_SET_MIN = 3'd2;
`ifdef TIMEKEEPER_ALARM_EN
    localparam logic [2:0] c_ALM_HR  = 3'd3;
    localparam logic [2:0] c_ALM_MIN = 3'd4;
`endif

    logic [2:0]           r_state;
    logic [2:0]           w_state_next;
    logic [c_PRESC_W-1:0] r_presc;
    logic [7:0]           r_hh;
    logic [7:0]           r_mm;
    logic [7:0]           r_ss;
    logic                 w_tick;
    logic                 w_inc;
    logic                 w_leave_set_min;
    logic [7:0]           w_disp_hh;
    logic [7:0]           w_disp_mm;
    logic [7:0]           w_disp_ss;

    // Two-digit BCD increment that wraps to 00 after the given last value.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] last_val);
        if (v == last_val)
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // A mode press in the same cycle swallows any increment press.
    assign w_inc           = btn_inc && !btn_mode;
    assign w_tick          = (r_state == c_RUN) && (r_presc == c_PRESC_LAST);
    assign w_leave_set_min = btn_mode && (r_state == c_SET_MIN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= c_RUN;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (btn_mode) begin
            case (r_state)
                c_RUN:     w_state_next = c_SET_HR;
                c_SET_HR:  w_state_next = c_SET_MIN;
`ifdef TIMEKEEPER_ALARM_EN
                c_SET_MIN: w_state_next = c_ALM_HR;
                c_ALM_HR:  w_state_next = c_ALM_MIN;
                c_ALM_MIN: w_state_next = c_RUN;
`else
                c_SET_MIN: w_state_next = c_RUN;
`endif
                default:   w_state_next = c_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_presc <= '0;
        else if ((r_state != c_RUN) || w_tick)
            r_presc <= '0;
        else
            r_presc <= r_presc + c_PRESC_W'(1);
    end

    // Ticks only happen in RUN, so they never collide with the set-mode edits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hh <= 8'h00;
            r_mm <= 8'h00;
            r_ss <= 8'h00;
        end else if (w_tick) begin
            r_ss <= bcd_inc(r_ss, 8'h59);
            if (r_ss == 8'h59) begin
                r_mm <= bcd_inc(r_mm, 8'h59);
                if (r_mm == 8'h59)
                    r_hh <= bcd_inc(r_hh, 8'h23);
            end
        end else begin
            if (w_inc && (r_state == c_SET_HR))
                r_hh <= bcd_inc(r_hh, 8'h23);
            if (w_inc && (r_state == c_SET_MIN))
                r_mm <= bcd_inc(r_mm, 8'h59);
            if (w_leave_set_min)
                r_ss <= 8'h00;
        end
    end

`ifdef TIMEKEEPER_ALARM_EN
    logic [7:0] r_alm_hh;
    logic [7:0] r_alm_mm;
    logic       r_armed;
    logic       r_alarm;
    logic       w_show_alarm;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_alm_hh <= 8'h00;
            r_alm_mm <= 8'h00;
            r_armed  <= 1'b0;
            r_alarm  <= 1'b0;
        end else begin
            if (w_inc && (r_state == c_ALM_HR))
                r_alm_hh <= bcd_inc(r_alm_hh, 8'h23);
            if (w_inc && (r_state == c_ALM_MIN))
                r_alm_mm <= bcd_inc(r_alm_mm, 8'h59);
            if (w_inc && (r_state == c_RUN))
                r_armed <= ~r_armed;
            r_alarm <= (r_state == c_RUN) && r_armed &&
                       (r_hh == r_alm_hh) && (r_mm == r_alm_mm);
        end
    end

    assign w_show_alarm = (r_state == c_ALM_HR) || (r_state == c_ALM_MIN);
    assign w_disp_hh    = w_show_alarm ? r_alm_hh : r_hh;
    assign w_disp_mm    = w_show_alarm ? r_alm_mm : r_mm;
    assign w_disp_ss    = w_show_alarm ? 8'h00    : r_ss;
    assign alarm        = r_alarm;
`else
    assign w_disp_hh = r_hh;
    assign w_disp_mm = r_mm;
    assign w_disp_ss = r_ss;
    assign alarm     = 1'b0;
`endif

    assign mode       = r_state;
    assign to_display = {w_disp_hh, w_disp_mm, w_disp_ss, 4'h0, 1'b0, r_state};

endmodule
`default_nettype wire

// File: tb/tb_bcd_timekeeper.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_timekeeper
// Summary  : Scoreboard bench for bcd_timekeeper at four ticks per second;
//            alarm scenarios follow TIMEKEEPER_ALARM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_timekeeper;

    localparam int c_TPS = 4;
`ifdef TIMEKEEPER_ALARM_EN
    localparam bit c_ALARM_EN      = 1'b1;
    localparam int c_EXIT_PRESSES  = 3;
`else
    localparam bit c_ALARM_EN      = 1'b0;
    localparam int c_EXIT_PRESSES  = 1;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        btn_mode = 1'b0;
    logic        btn_inc = 1'b0;
    logic [31:0] to_display;
    logic [2:0]  mode;
    logic        alarm;

    int m_st, m_presc, m_hh, m_mm, m_ss, m_ahh, m_amm;
    bit m_armed, m_alarm;

    logic [31:0] exp_q[$];
    logic        alm_q[$];

    int n_checks = 0;
    int n_errors = 0;

    bcd_timekeeper #(.TICKS_PER_SEC(c_TPS)) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_mode   (btn_mode),
        .btn_inc    (btn_inc),
        .to_display (to_display),
        .mode       (mode),
        .alarm      (alarm)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, actual running, required finished");
        $fatal(1, "timeout");
    end

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic [31:0] model_display();
        if (m_st == 3 || m_st == 4)
            return {to_bcd(m_ahh), to_bcd(m_amm), 8'h00, 4'h0, 1'b0, 3'(m_st)};
        return {to_bcd(m_hh), to_bcd(m_mm), to_bcd(m_ss), 4'h0, 1'b0, 3'(m_st)};
    endfunction

    task automatic model_reset();
        m_st = 0; m_presc = 0; m_hh = 0; m_mm = 0; m_ss = 0;
        m_ahh = 0; m_amm = 0; m_armed = 0; m_alarm = 0;
        exp_q.delete();
        alm_q.delete();
    endtask

    // Advance the reference model by one clock edge, queue its expectation,
    // then apply the same buttons to the DUT for that edge.
    task automatic drive(input bit m, input bit i);
        bit tick;
        tick    = (m_st == 0) && (m_presc == c_TPS - 1);
        m_alarm = c_ALARM_EN && (m_st == 0) && m_armed && (m_hh == m_ahh) && (m_mm == m_amm);
        m_presc = (m_st != 0 || tick) ? 0 : m_presc + 1;
        if (tick) begin
            m_ss++;
            if (m_ss == 60) begin
                m_ss = 0;
                m_mm++;
                if (m_mm == 60) begin
                    m_mm = 0;
                    m_hh = (m_hh + 1) % 24;
                end
            end
        end
        if (m) begin
            if (m_st == 2) m_ss = 0;
            case (m_st)
                0:       m_st = 1;
                1:       m_st = 2;
                2:       m_st = c_ALARM_EN ? 3 : 0;
                3:       m_st = 4;
                default: m_st = 0;
            endcase
        end else if (i) begin
            case (m_st)
                0:       if (c_ALARM_EN) m_armed = !m_armed;
                1:       m_hh  = (m_hh + 1) % 24;
                2:       m_mm  = (m_mm + 1) % 60;
                3:       m_ahh = (m_ahh + 1) % 24;
                default: m_amm = (m_amm + 1) % 60;
            endcase
        end
        exp_q.push_back(model_display());
        alm_q.push_back(m_alarm);
        btn_mode = m;
        btn_inc  = i;
        @(posedge clk);
        #1;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] exp_d;
        logic        exp_a;
        logic [1:0]  stim[$];
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        n_checks++;
        if (to_display !== 32'h0) begin n_errors++; $display("FAIL reset_display: got %h want 00000000", to_display); end
        n_checks++;
        if (mode !== 3'd0) begin n_errors++; $display("FAIL reset_mode: got %0d want 0", mode); end
        n_checks++;
        if (alarm !== 1'b0) begin n_errors++; $display("FAIL reset_alarm: got %b want 0", alarm); end
        reset = 1'b0;

        stim = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b01, 2'b01};
        foreach (stim[k]) begin
            drive(stim[k][1], stim[k][0]);
            exp_d = exp_q.pop_front();
            exp_a = alm_q.pop_front();
            n_checks++;
            if (to_display !== exp_d || alarm !== exp_a) begin
                n_errors++;
                $display("FAIL reset_run step %0d: got display=%h alarm=%b want display=%h alarm=%b", k, to_display, alarm, exp_d, exp_a);
            end
        end

        // Reset in the middle of a setting sequence, between clock edges.
        #3 reset = 1'b1;
        #1;
        n_checks++;
        if (to_display !== 32'h0 || mode !== 3'd0 || alarm !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_abort: got display=%h mode=%0d alarm=%b want 00000000/0/0", to_display, mode, alarm);
        end
        model_reset();
        #1 reset = 1'b0;

        stim = '{2'b00, 2'b00, 2'b00};
        foreach (stim[k]) begin
            drive(stim[k][1], stim[k][0]);
            exp_d = exp_q.pop_front();
            exp_a = alm_q.pop_front();
            n_checks++;
            if (to_display !== exp_d || alarm !== exp_a) begin
                n_errors++;
                $display("FAIL reset_count step %0d: got display=%h alarm=%b want display=%h alarm=%b", k, to_display, alarm, exp_d, exp_a);
            end
        end

        // Prescaler is one edge short of a tick here.
        #3 reset = 1'b1;
        #1;
        n_checks++;
        if (to_display !== 32'h0 || mode !== 3'd0 || alarm !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_midcount: got display=%h mode=%0d alarm=%b want 00000000/0/0", to_display, mode, alarm);
        end
        model_reset();
        #1 reset = 1'b0;

        stim = '{2'b00, 2'b00, 2'b00, 2'b00};
        foreach (stim[k]) begin
            drive(stim[k][1], stim[k][0]);
            exp_d = exp_q.pop_front();
            exp_a = alm_q.pop_front();
            n_checks++;
            if (to_display !== exp_d || alarm !== exp_a) begin
                n_errors++;
                $display("FAIL reset_resume step %0d: got display=%h alarm=%b want display=%h alarm=%b", k, to_display, alarm, exp_d, exp_a);
            end
        end
        n_checks++;
        if (to_display !== 32'h00000100) begin n_errors++; $display("FAIL reset_first_tick: got %h want 00000100", to_display); end
    endtask

    task automatic test_set_time();
        logic [31:0] exp_d;
        logic        exp_a;
        logic [1:0]  stim[$];
        stim.push_back(2'b10);
        repeat (23) stim.push_back(2'b01);
        stim.push_back(2'b10);
        repeat (59) stim.push_back(2'b01);
        repeat (c_EXIT_PRESSES) stim.push_back(2'b10);
        foreach (stim[k]) begin
            drive(stim[k][1], stim[k][0]);
            exp_d = exp_q.pop_front();
            exp_a = alm_q.pop_front();
            n_checks++;
            if (to_display !== exp_d || alarm !== exp_a) begin
                n_errors++;
                $display("FAIL set_time step %0d: got display=%h alarm=%b want display=%h alarm=%b", k, to_display, alarm, exp_d, exp_a);
            end
        end
        n_checks++;
        if (to_display !== 32'h23590000) begin n_errors++; $display("FAIL set_time_entry: got %h want 23590000", to_display); end

        for (int c = 0; c < 240; c++) begin
            drive(1'b0, 1'b0);
            exp_d = exp_q.pop_front();
            exp_a = alm_q.pop_front();
            n_checks++;
            if (to_display !== exp_d || alarm !== exp_a) begin
                n_errors++;
                $display("FAIL run_count cycle %0d: got display=%h alarm=%b want display=%h alarm=%b", c, to_display, alarm, exp_d, exp_a);
            end
            if (c == 235) begin
                n_checks++;
                if (to_display !== 32'h23595900) begin n_errors++; $display("FAIL run_235959: got %h want 23595900", to_display); end
            end
        end
        n_checks++;
        if (to_display !== 32'h00000000) begin n_errors++; $display("FAIL day_rollover: got %h want 00000000", to_display); end
    endtask

    task automatic test_field_wrap();
        logic [31:0] exp_d;
        logic        exp_a;
        logic [1:0]  stim[$];
        stim.push_back(2'b10);
        repeat (24) stim.push_back(2'b01);
        foreach (stim[k]) begin
            drive(stim[k][1], stim[k][0]);
            exp_d = exp_q.pop_front();
            exp_a = alm_q.pop_front();
            n_checks++;
            if (to_display !== exp_d || alarm !== exp_a) begin
                n_errors++;
                $display("FAIL hour_set step %0d: got display=%h alarm=%b want display=%h alarm=%b", k, to_display, alarm, exp_d, exp_a);
            end
        end
        n_checks++;
        if (to_display !== 32'h00000001) begin n_errors++; $display("FAIL hour_wrap: got %h want 00000001", to_display); end

        for (int c = 0; c < 5; c++) begin
            drive(1'b0, 1'b1);
            exp_d = exp_q.pop_front();
            exp_a = alm_q.pop_front();
            n_checks++;
            if (to_display !== exp_d || alarm !== exp_a) begin
                n_errors++;
                $display("FAIL hour_to_05 step %0d: got display=%h alarm=%b want display=%h alarm=%b", c, to_display, alarm, exp_d, exp_a);
            end
        end
    endtask

    task automatic test_same_cycle();
        logic [31:0] exp_d;
        logic        exp_a;
        drive(1'b1, 1'b1);
        exp_d = exp_q.pop_front();
        exp_a = alm_q.pop_front();
        n_checks++;
        if (to_display !== exp_d || alarm !== exp_a) begin
            n_errors++;
            $display("FAIL same_cycle: got display=%h alarm=%b want display=%h alarm=%b", to_display, alarm, exp_d, exp_a);
        end
        n_checks++;
        if (mode !== 3'd2 || to_display[31:24] !== 8'h05) begin
            n_errors++;
            $display("FAIL mode_wins: got mode=%0d hours=%h want mode=2 hours=05", mode, to_display[31:24]);
        end
    endtask

    task automatic test_min_wrap();
        logic [31:0] exp_d;
        logic        exp_a;
        logic [1:0]  stim[$];
        repeat (60) stim.push_back(2'b01);
        foreach (stim[k]) begin
            drive(stim[k][1], stim[k][0]);
            exp_d = exp_q.pop_front();
            exp_a = alm_q.pop_front();
            n_checks++;
            if (to_display !== exp_d || alarm !== exp_a) begin
                n_errors++;
                $display("FAIL min_set step %0d: got display=%h alarm=%b want display=%h alarm=%b", k, to_display, alarm, exp_d, exp_a);
            end
        end
        n_checks++;
        if (to_display[31:16] !== 16'h0500) begin n_errors++; $display("FAIL min_wrap_no_carry: got %h want 0500", to_display[31:16]); end

        stim.delete();
        repeat (c_EXIT_PRESSES) stim.push_back(2'b10);
        foreach (stim[k]) begin
            drive(stim[k][1], stim[k][0]);
            exp_d = exp_q.pop_front();
            exp_a = alm_q.pop_front();
            n_checks++;
            if (to_display !== exp_d || alarm !== exp_a) begin
                n_errors++;
                $display("FAIL min_exit step %0d: got display=%h alarm=%b want display=%h alarm=%b", k, to_display, alarm, exp_d, exp_a);
            end
        end
        n_checks++;
        if (to_display !== 32'h05000000) begin n_errors++; $display("FAIL back_to_run: got %h want 05000000", to_display); end
    endtask

`ifdef TIMEKEEPER_ALARM_EN
    task automatic test_alarm();
        logic [31:0] exp_d;
        logic        exp_a;
        logic [1:0]  stim[$];
        #3 reset = 1'b1;
        model_reset();
        #2 reset = 1'b0;

        stim = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
        foreach (stim[k]) begin
            drive(stim[k][1], stim[k][0]);
            exp_d = exp_q.pop_front();
            exp_a = alm_q.pop_front();
            n_checks++;
            if (to_display !== exp_d || alarm !== exp_a) begin
                n_errors++;
                $display("FAIL alarm_set step %0d: got display=%h alarm=%b want display=%h alarm=%b", k, to_display, alarm, exp_d, exp_a);
            end
        end
        n_checks++;
        if (to_display !== 32'h00010004) begin n_errors++; $display("FAIL alarm_view: got %h want 00010004", to_display); end

        // Back to RUN, arm, then run until the model reports 00:01:00.
        stim = '{2'b10, 2'b01};
        for (int c = 0; c < 400 && (c < 2 || model_display() !== 32'h00010000); c++) begin
            if (c < 2) drive(stim[c][1], stim[c][0]);
            else       drive(1'b0, 1'b0);
            exp_d = exp_q.pop_front();
            exp_a = alm_q.pop_front();
            n_checks++;
            if (to_display !== exp_d || alarm !== exp_a) begin
                n_errors++;
                $display("FAIL alarm_run cycle %0d: got display=%h alarm=%b want display=%h alarm=%b", c, to_display, alarm, exp_d, exp_a);
            end
        end
        n_checks++;
        if (to_display !== 32'h00010000 || alarm !== 1'b0) begin
            n_errors++;
            $display("FAIL alarm_pre_rise: got display=%h alarm=%b want 00010000/0", to_display, alarm);
        end

        // Rise, disarm during the match, re-arm.
        stim = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b00};
        foreach (stim[k]) begin
            drive(stim[k][1], stim[k][0]);
            exp_d = exp_q.pop_front();
            exp_a = alm_q.pop_front();
            n_checks++;
            if (to_display !== exp_d || alarm !== exp_a) begin
                n_errors++;
                $display("FAIL alarm_arm step %0d: got display=%h alarm=%b want display=%h alarm=%b", k, to_display, alarm, exp_d, exp_a);
            end
            if (k == 0) begin
                n_checks++;
                if (alarm !== 1'b1) begin n_errors++; $display("FAIL alarm_rise: got %b want 1", alarm); end
            end
            if (k == 2) begin
                n_checks++;
                if (alarm !== 1'b0) begin n_errors++; $display("FAIL alarm_disarm: got %b want 0", alarm); end
            end
            if (k == 4) begin
                n_checks++;
                if (alarm !== 1'b1) begin n_errors++; $display("FAIL alarm_rearm: got %b want 1", alarm); end
            end
        end

        for (int c = 0; c < 400 && model_display() !== 32'h00020000; c++) begin
            drive(1'b0, 1'b0);
            exp_d = exp_q.pop_front();
            exp_a = alm_q.pop_front();
            n_checks++;
            if (to_display !== exp_d || alarm !== exp_a) begin
                n_errors++;
                $display("FAIL alarm_hold cycle %0d: got display=%h alarm=%b want display=%h alarm=%b", c, to_display, alarm, exp_d, exp_a);
            end
        end
        n_checks++;
        if (to_display !== 32'h00020000 || alarm !== 1'b1) begin
            n_errors++;
            $display("FAIL alarm_pre_fall: got display=%h alarm=%b want 00020000/1", to_display, alarm);
        end
        drive(1'b0, 1'b0);
        exp_d = exp_q.pop_front();
        exp_a = alm_q.pop_front();
        n_checks++;
        if (to_display !== exp_d || alarm !== 1'b0 || exp_a !== 1'b0) begin
            n_errors++;
            $display("FAIL alarm_fall: got display=%h alarm=%b want display=%h alarm=0", to_display, alarm, exp_d);
        end
    endtask
`else
    task automatic test_no_alarm();
        logic [31:0] exp_d;
        logic        exp_a;
        int          codes[5] = '{1, 2, 0, 1, 2};
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b0);
            exp_d = exp_q.pop_front();
            exp_a = alm_q.pop_front();
            n_checks++;
            if (to_display !== exp_d || mode !== 3'(codes[k]) || alarm !== 1'b0 || exp_a !== 1'b0) begin
                n_errors++;
                $display("FAIL no_alarm_mode %0d: got display=%h mode=%0d alarm=%b want display=%h mode=%0d alarm=0", k, to_display, mode, alarm, exp_d, codes[k]);
            end
        end
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b1);
        void'(exp_q.pop_front());
        void'(alm_q.pop_front());
        exp_d = exp_q.pop_front();
        exp_a = alm_q.pop_front();
        n_checks++;
        if (to_display !== exp_d || mode !== 3'd0 || alarm !== 1'b0) begin
            n_errors++;
            $display("FAIL no_alarm_inc_run: got display=%h mode=%0d alarm=%b want display=%h mode=0 alarm=0", to_display, mode, alarm, exp_d);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_set_time();
        test_field_wrap();
        test_same_cycle();
        test_min_wrap();
`ifdef TIMEKEEPER_ALARM_EN
        test_alarm();
`else
        test_no_alarm();
`endif
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
